// File: rtl/amns_pkg.sv
// Shared types and defaults for the self-sequenced AMNS processing element.
package amns_pkg;

    localparam int W_DEF      = 17;
    localparam int ACC_W_DEF  = 48;
    localparam int LAMBDA_DEF = 2;
    localparam int N_DEF      = 5;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        DRAIN,
        QMUL,
        RMUL,
        SHIFT,
        OUT
    } pe_state_t;

    // Sign-extends the low 'width' bits of v to the full 64 bits.
    function automatic logic [63:0] sext_acc(input logic [63:0] v, input int unsigned width);
        logic signed [63:0] t;
        t = signed'(v << (64 - width));
        return t >>> (64 - width);
    endfunction

endpackage

// File: rtl/amns_pe_seq_if.sv
// Operand, control and result bundle between an AMNS PE and its row driver.
interface amns_pe_seq_if #(
    parameter int W     = 17,
    parameter int ACC_W = 48
);
    logic             start_i;
    logic [ACC_W-1:0] acc_init_i;
    logic [W-1:0]     m_i;
    logic [W-1:0]     mprime_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [W-1:0]     a_i;
    logic [W-1:0]     b_i;
    logic             lam_i;
    logic             busy_o;
    logic [W-1:0]     q_o;
    logic             q_valid_o;
    logic             res_valid_o;
    logic             res_ready_i;
    logic [ACC_W-1:0] res_o;

    modport master (
        output start_i, acc_init_i, m_i, mprime_i, in_valid_i, a_i, b_i, lam_i, res_ready_i,
        input  in_ready_o, busy_o, q_o, q_valid_o, res_valid_o, res_o
    );

    modport slave (
        input  start_i, acc_init_i, m_i, mprime_i, in_valid_i, a_i, b_i, lam_i, res_ready_i,
        output in_ready_o, busy_o, q_o, q_valid_o, res_valid_o, res_o
    );
endinterface

// File: rtl/amns_mul_stage.sv
// Signed MAC multiplier: operand sign extension, optional LAMBDA pre-scale,
// multiply, and one product register.
module amns_mul_stage #(
    parameter int W      = 17,
    parameter int LAMBDA = 2,
    parameter int S_W    = W + 3,
    parameter int P_W    = 2 * W + 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_issue,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    input  logic           i_lam,
    output logic           o_prod_valid,
    output logic [P_W-1:0] o_prod
);
    localparam logic signed [S_W-1:0] LAM_S = S_W'(LAMBDA);

    logic signed [W:0]     w_a_ext;
    logic signed [W:0]     w_b_ext;
    logic signed [S_W-1:0] w_a_scaled;
    logic signed [P_W-1:0] w_prod;
    logic                  r_prod_valid;
    logic [P_W-1:0]        r_prod;

    // Widen before scaling so LAMBDA * (-2^(W-1)) cannot overflow.
    assign w_a_ext    = (W + 1)'(signed'(i_a));
    assign w_b_ext    = (W + 1)'(signed'(i_b));
    assign w_a_scaled = i_lam ? S_W'(w_a_ext) * LAM_S : S_W'(w_a_ext);
    assign w_prod     = P_W'(w_a_scaled) * P_W'(w_b_ext);

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prod_valid <= 1'b0;
            r_prod       <= '0;
        end else begin
            r_prod_valid <= i_issue;
            if (i_issue) r_prod <= w_prod;
        end
    end

    assign o_prod_valid = r_prod_valid;
    assign o_prod       = r_prod;
endmodule

// File: rtl/amns_pe_seq.sv
// Self-sequenced AMNS PE: N-beat signed MAC, Montgomery low-limb reduction,
// then a W-bit arithmetic shift; the result is held until consumed.
module amns_pe_seq
    import amns_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LAMBDA = LAMBDA_DEF,
    parameter int N      = N_DEF
) (
    input  logic          clock_i,
    input  logic          reset_i,
    amns_pe_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(N + 1);
    localparam int S_W   = W + 1 + $clog2(LAMBDA + 1);
    localparam int P_W   = S_W + W + 1;

    pe_state_t        r_state;
    logic             r_sub;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_rprod;
    logic [W-1:0]     r_q;
    logic             r_q_valid;
    logic             r_busy;
    logic             r_in_ready;
    logic             r_res_valid;

    logic             w_issue;
    logic             w_prod_valid;
    logic [P_W-1:0]   w_prod;
    logic [ACC_W-1:0] w_prod_ext;
    logic [W-1:0]     w_q;

    assign w_issue    = bus.in_valid_i & r_in_ready;
    assign w_prod_ext = ACC_W'(sext_acc(64'(w_prod), P_W));
    assign w_q        = W'(r_acc[W-1:0] * bus.mprime_i);

    amns_mul_stage #(
        .W      (W),
        .LAMBDA (LAMBDA),
        .S_W    (S_W),
        .P_W    (P_W)
    ) u_mul (
        .i_clk        (clock_i),
        .i_rst        (reset_i),
        .i_issue      (w_issue),
        .i_a          (bus.a_i),
        .i_b          (bus.b_i),
        .i_lam        (bus.lam_i),
        .o_prod_valid (w_prod_valid),
        .o_prod       (w_prod)
    );

    // DRAIN, QMUL and RMUL each last two cycles, tracked by r_sub.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= IDLE;
            r_sub       <= 1'b0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_rprod     <= '0;
            r_q         <= '0;
            r_q_valid   <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_q_valid <= 1'b0;
            if (w_prod_valid) r_acc <= r_acc + w_prod_ext;

            case (r_state)
                IDLE: begin
                    if (bus.start_i) begin
                        r_state    <= MAC;
                        r_acc      <= bus.acc_init_i;
                        r_cnt      <= '0;
                        r_sub      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b1;
                    end
                end
                MAC: begin
                    if (w_issue) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(N - 1)) begin
                            r_state    <= DRAIN;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    r_sub <= ~r_sub;
                    if (r_sub) r_state <= QMUL;
                end
                QMUL: begin
                    r_sub <= ~r_sub;
                    if (r_sub) begin
                        r_q       <= w_q;
                        r_q_valid <= 1'b1;
                        r_state   <= RMUL;
                    end
                end
                RMUL: begin
                    r_sub <= ~r_sub;
                    if (!r_sub) begin
                        r_rprod <= ACC_W'(r_q) * ACC_W'(bus.m_i);
                    end else begin
                        r_acc   <= r_acc + r_rprod;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_acc       <= ACC_W'($signed(r_acc) >>> W);
                    r_res_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (bus.res_ready_i) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    a_low_limb_zero: assert property (@(posedge clock_i) disable iff (reset_i)
        (r_state == SHIFT) |-> (r_acc[W-1:0] == '0));

    assign bus.in_ready_o  = r_in_ready;
    assign bus.busy_o      = r_busy;
    assign bus.q_o         = r_q;
    assign bus.q_valid_o   = r_q_valid;
    assign bus.res_valid_o = r_res_valid;
    assign bus.res_o       = r_acc;
endmodule

// File: tb/tb_amns_pe_seq.sv
// Scoreboard bench for amns_pe_seq: an N=2 and an N=1 instance driven by tasks,
// checked by per-instance monitors against an arithmetic reference model.
module tb_amns_pe_seq;
    localparam int     W      = 17;
    localparam int     ACC_W  = 48;
    localparam int     LAMBDA = 2;
    localparam longint M      = 3;
    localparam longint MPRIME = 87381;
    localparam longint MASK_W   = (longint'(1) << W) - 1;
    localparam longint MASK_ACC = (longint'(1) << ACC_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    amns_pe_seq_if #(.W(W), .ACC_W(ACC_W)) ifa ();
    amns_pe_seq_if #(.W(W), .ACC_W(ACC_W)) ifb ();

    amns_pe_seq #(.W(W), .ACC_W(ACC_W), .LAMBDA(LAMBDA), .N(2)) dut_a (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (ifa)
    );

    amns_pe_seq #(.W(W), .ACC_W(ACC_W), .LAMBDA(LAMBDA), .N(1)) dut_b (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (ifb)
    );

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;
    bit     rnd_ready = 1'b0;
    longint qa_q[$];
    longint ra_q[$];
    longint qb_q[$];
    longint rb_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Row result from first principles: MAC sum, Montgomery quotient, exact shift.
    function automatic void model(input longint init, input int av[8], input int bv[8],
                                  input bit lv[8], input int n,
                                  output longint res, output longint q);
        longint s, acc, t;
        s = init;
        for (int i = 0; i < n; i++)
            s += longint'(av[i]) * longint'(bv[i]) * longint'(lv[i] ? LAMBDA : 1);
        acc = s & MASK_ACC;
        q   = ((acc & MASK_W) * MPRIME) & MASK_W;
        t   = (acc + q * M) & MASK_ACC;
        if (t >= (longint'(1) << (ACC_W - 1))) t -= longint'(1) << ACC_W;
        res = (t >>> W) & MASK_ACC;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (ifa.q_valid_o) begin
                if (qa_q.size() == 0) check("a_q_unexpected", longint'(qa_q.size()), 1);
                else check("a_q", longint'(ifa.q_o), qa_q.pop_front());
            end
            if (ifa.res_valid_o && ifa.res_ready_i) begin
                if (ra_q.size() == 0) check("a_res_unexpected", longint'(ra_q.size()), 1);
                else check("a_res", longint'(ifa.res_o), ra_q.pop_front());
            end
            if (ifb.q_valid_o) begin
                if (qb_q.size() == 0) check("b_q_unexpected", longint'(qb_q.size()), 1);
                else check("b_q", longint'(ifb.q_o), qb_q.pop_front());
            end
            if (ifb.res_valid_o && ifb.res_ready_i) begin
                if (rb_q.size() == 0) check("b_res_unexpected", longint'(rb_q.size()), 1);
                else check("b_res", longint'(ifb.res_o), rb_q.pop_front());
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rnd_ready) ifa.res_ready_i = ($urandom_range(0, 3) != 0);
    end

    task automatic row_a(input longint init, input int av[8], input int bv[8], input bit lv[8],
                         input int stall, input bit rnd, output longint st);
        longint r, q;
        int     k;
        bit     ok;
        model(init, av, bv, lv, 2, r, q);
        k = 0;
        while (ifa.busy_o !== 1'b0 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 200) check("a_idle_timeout", longint'(k), 0);
        qa_q.push_back(q);
        ra_q.push_back(r);
        ifa.acc_init_i = init[ACC_W-1:0];
        ifa.start_i    = 1'b1;
        st = cyc;
        @(posedge clk);
        #1;
        ifa.start_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            int ns;
            ns = rnd ? int'($urandom_range(0, 2)) : ((i > 0) ? stall : 0);
            repeat (ns) begin
                @(posedge clk);
                #1;
            end
            ifa.a_i        = av[i][W-1:0];
            ifa.b_i        = bv[i][W-1:0];
            ifa.lam_i      = lv[i];
            ifa.in_valid_i = 1'b1;
            k  = 0;
            ok = 1'b0;
            while (!ok && k < 50) begin
                @(negedge clk);
                ok = (ifa.in_ready_o === 1'b1);
                @(posedge clk);
                #1;
                k++;
            end
            if (!ok) check("a_beat_timeout", longint'(k), 0);
            ifa.in_valid_i = 1'b0;
            ifa.a_i        = W'($urandom);
            ifa.b_i        = W'($urandom);
        end
    endtask

    task automatic wait_res_a(output longint c);
        int k;
        k = 0;
        @(negedge clk);
        while (ifa.res_valid_o !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) check("a_res_timeout", longint'(k), 0);
        c = cyc;
    endtask

    initial begin
        int          c1a[8], c1b[8], av[8], bv[8];
        bit          c1l[8], lv[8];
        longint      st, c, r, q, init;
        logic [W-1:0] rv;
        int          k;

        c1a = '{5, 1, 0, 0, 0, 0, 0, 0};
        c1b = '{7, 1, 0, 0, 0, 0, 0, 0};
        c1l = '{0, 1, 0, 0, 0, 0, 0, 0};

        rst = 1'b1;
        ifa.start_i = 1'b0; ifa.acc_init_i = '0; ifa.m_i = W'(M); ifa.mprime_i = W'(MPRIME);
        ifa.in_valid_i = 1'b0; ifa.a_i = '0; ifa.b_i = '0; ifa.lam_i = 1'b0; ifa.res_ready_i = 1'b1;
        ifb.start_i = 1'b0; ifb.acc_init_i = '0; ifb.m_i = W'(M); ifb.mprime_i = W'(MPRIME);
        ifb.in_valid_i = 1'b0; ifb.a_i = '0; ifb.b_i = '0; ifb.lam_i = 1'b0; ifb.res_ready_i = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",      longint'(ifa.busy_o), 0);
        check("rst_in_ready",  longint'(ifa.in_ready_o), 0);
        check("rst_res_valid", longint'(ifa.res_valid_o), 0);
        check("rst_q_valid",   longint'(ifa.q_valid_o), 0);
        check("rst_q",         longint'(ifa.q_o), 0);
        check("rst_res",       longint'(ifa.res_o), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Beats offered while idle must be ignored.
        ifa.in_valid_i = 1'b1; ifa.a_i = W'(100); ifa.b_i = W'(100);
        repeat (2) begin @(posedge clk); #1; end
        ifa.in_valid_i = 1'b0;

        // Case 1: nominal row, then start during the single OUT cycle.
        row_a(0, c1a, c1b, c1l, 0, 1'b0, st);
        wait_res_a(c);
        check("c1_latency", c - st, 10);
        ifa.start_i = 1'b1;
        @(posedge clk);
        #1;
        ifa.start_i = 1'b0;
        @(negedge clk);
        check("c1_idle_busy",     longint'(ifa.busy_o), 0);
        check("c1_idle_in_ready", longint'(ifa.in_ready_o), 0);
        @(posedge clk);
        #1;

        // Case 2: N=1 sign-extension row on the second instance.
        av = '{-1, 0, 0, 0, 0, 0, 0, 0};
        bv = '{1, 0, 0, 0, 0, 0, 0, 0};
        lv = '{0, 0, 0, 0, 0, 0, 0, 0};
        model(0, av, bv, lv, 1, r, q);
        qb_q.push_back(q);
        rb_q.push_back(r);
        ifb.start_i = 1'b1;
        st = cyc;
        @(posedge clk);
        #1;
        ifb.start_i = 1'b0;
        ifb.a_i = W'(-1); ifb.b_i = W'(1); ifb.lam_i = 1'b0; ifb.in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        ifb.in_valid_i = 1'b0;
        k = 0;
        @(negedge clk);
        while (ifb.res_valid_o !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        if (k >= 100) check("b_res_timeout", longint'(k), 0);
        check("c2_latency", cyc - st, 9);
        @(posedge clk);
        #1;

        // Case 3: three idle cycles between the beats.
        row_a(0, c1a, c1b, c1l, 3, 1'b0, st);
        wait_res_a(c);
        check("c3_latency", c - st, 13);
        @(posedge clk);
        #1;

        // Case 4: consumer stalls in OUT, start pulse must not restart the row.
        ifa.res_ready_i = 1'b0;
        row_a(0, c1a, c1b, c1l, 0, 1'b0, st);
        wait_res_a(c);
        check("c4_res_hold", longint'(ifa.res_o), 2);
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            ifa.start_i     = (i == 2);
            ifa.res_ready_i = (i == 5);
            @(negedge clk);
            check("c4_res_hold",  longint'(ifa.res_o), 2);
            check("c4_busy",      longint'(ifa.busy_o), 1);
            check("c4_in_ready",  longint'(ifa.in_ready_o), 0);
        end
        @(posedge clk);
        #1;
        ifa.start_i = 1'b0;
        @(negedge clk);
        check("c4_idle_busy", longint'(ifa.busy_o), 0);
        @(posedge clk);
        #1;

        // Case 5: reset in the second RMUL cycle discards the row.
        row_a(0, c1a, c1b, c1l, 0, 1'b0, st);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        void'(ra_q.pop_back());
        #1;
        check("c5_busy",      longint'(ifa.busy_o), 0);
        check("c5_res_valid", longint'(ifa.res_valid_o), 0);
        check("c5_q",         longint'(ifa.q_o), 0);
        check("c5_res",       longint'(ifa.res_o), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        row_a(0, c1a, c1b, c1l, 0, 1'b0, st);
        wait_res_a(c);
        check("c5_latency", c - st, 10);
        @(posedge clk);
        #1;

        // Case 6: randomised rows with random stalls and consumer back-pressure.
        rnd_ready = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < 8; i++) begin
                rv    = W'($urandom);
                av[i] = int'($signed(rv));
                rv    = W'($urandom);
                bv[i] = int'($signed(rv));
                lv[i] = 1'($urandom);
            end
            init = longint'({$urandom(), 16'($urandom())});
            row_a(init, av, bv, lv, 0, 1'b1, st);
        end
        k = 0;
        while ((ra_q.size() != 0 || qa_q.size() != 0) && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        rnd_ready = 1'b0;
        check("final_res_queue", longint'(ra_q.size()), 0);
        check("final_q_queue",   longint'(qa_q.size()), 0);
        check("final_b_queue",   longint'(rb_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
